// File: rtl/sar_adc_controller_pkg.sv
// Shared SAR ADC types and default sizing, imported by the controller, its interface and its timer.
package adc_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    DECIDE = 2'd2,
    DONE   = 2'd3
  } sar_state_t;

  localparam int SAR_WIDTH_DEFAULT    = 8;
  localparam int SAR_SETTLE_DEFAULT   = 4;
  localparam int SAR_AVG_LOG2_DEFAULT = 2;

endpackage

// File: rtl/sar_adc_controller_if.sv
// Handshake and data bundle between the menu FSM / comparator and the SAR controller.
interface sar_adc_controller_if
  import adc_pkg::*;
#(
  parameter int WIDTH = SAR_WIDTH_DEFAULT
);
  logic             enable;
  logic             start;
  logic             comp_in;
  logic [WIDTH-1:0] dac_code;
  logic             busy;
  logic [WIDTH-1:0] result;
  logic             result_valid;

  modport master (
    output enable, start, comp_in,
    input  dac_code, busy, result, result_valid
  );

  modport slave (
    input  enable, start, comp_in,
    output dac_code, busy, result, result_valid
  );
endinterface

// File: rtl/sar_adc_controller_settle_timer.sv
// Loadable settle down-counter: done is high on terminal count, SETTLE_CYCLES cycles after load.
module sar_settle_timer
  import adc_pkg::*;
#(
  parameter int SETTLE_CYCLES = SAR_SETTLE_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  output logic done
);
  localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES + 1) : 1;

  logic [CNT_W-1:0] count;

  // Loading SETTLE_CYCLES-1 and ending at zero gives exactly SETTLE_CYCLES cycles after load.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= CNT_W'(SETTLE_CYCLES - 1);
    end else if (count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign done = (count == '0);
endmodule

// File: rtl/sar_adc_controller.sv
// Successive-approximation conversion sequencer driving an external DAC and sampling a comparator.
// Optional SAR_AVG_EN averages 2^AVG_LOG2 back-to-back conversions per start.
module sar_adc_controller
  import adc_pkg::*;
#(
  parameter int WIDTH         = SAR_WIDTH_DEFAULT,
  parameter int SETTLE_CYCLES = SAR_SETTLE_DEFAULT,
  parameter int AVG_LOG2      = SAR_AVG_LOG2_DEFAULT
) (
  input  logic                  clk,
  input  logic                  reset,
  sar_adc_controller_if.slave   bus
);
  // state  | meaning
  // IDLE   | waiting for start, dac_code holds last code (0 after abort)
  // SETTLE | trial code on DAC, waiting SETTLE_CYCLES
  // DECIDE | sample comparator, keep/clear current bit
  // DONE   | publish result, strobe result_valid on exit
  localparam logic [1:0] ST_IDLE   = 2'(IDLE);
  localparam logic [1:0] ST_SETTLE = 2'(SETTLE);
  localparam logic [1:0] ST_DECIDE = 2'(DECIDE);
  localparam logic [1:0] ST_DONE   = 2'(DONE);

  localparam int IDX_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [WIDTH-1:0] MSB_CODE = WIDTH'(1) << (WIDTH - 1);

  logic [1:0]       state;
  logic [WIDTH-1:0] dac_code;
  logic [WIDTH-1:0] result;
  logic             result_valid;
  logic [IDX_W-1:0] idx;

  logic             timer_load;
  logic             timer_done;
  logic [WIDTH-1:0] idx_mask;
  logic [WIDTH-1:0] decided_code;
  logic [WIDTH-1:0] done_value;
  logic             last_bit;
  logic             restart;
  logic             accept;

  assign idx_mask     = WIDTH'(1) << idx;
  assign decided_code = bus.comp_in ? dac_code : (dac_code & ~idx_mask);
  assign last_bit     = (idx == '0);
  assign accept       = (state == ST_IDLE) && bus.start;

`ifdef SAR_AVG_EN
  localparam int N_CONV = 1 << AVG_LOG2;
  localparam int CNT_W  = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam int ACC_W  = WIDTH + AVG_LOG2;

  logic [ACC_W-1:0] acc;
  logic [CNT_W-1:0] conv_cnt;
  logic             last_conv;

  assign last_conv  = (conv_cnt == CNT_W'(N_CONV - 1));
  assign restart    = last_bit && !last_conv;
  assign done_value = WIDTH'(acc >> AVG_LOG2);

  always_ff @(posedge clk) begin
    if (reset) begin
      acc      <= '0;
      conv_cnt <= '0;
    end else if (bus.enable) begin
      if (accept) begin
        acc      <= '0;
        conv_cnt <= '0;
      end else if (state == ST_DECIDE && last_bit) begin
        acc      <= acc + ACC_W'(decided_code);
        conv_cnt <= conv_cnt + 1'b1;
      end
    end
  end
`else
  assign restart    = 1'b0;
  assign done_value = dac_code;
`endif

  always_comb begin
    timer_load = 1'b0;
    if (bus.enable) begin
      if (accept)
        timer_load = 1'b1;
      else if (state == ST_DECIDE)
        timer_load = !last_bit || restart;
    end
  end

  sar_settle_timer #(
    .SETTLE_CYCLES (SETTLE_CYCLES)
  ) u_settle_timer (
    .clk   (clk),
    .reset (reset),
    .load  (timer_load),
    .done  (timer_done)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= ST_IDLE;
      dac_code     <= '0;
      result       <= '0;
      result_valid <= 1'b0;
      idx          <= IDX_W'(WIDTH - 1);
    end else begin
      result_valid <= 1'b0;
      if (!bus.enable) begin
        state    <= ST_IDLE;
        dac_code <= '0;
        idx      <= IDX_W'(WIDTH - 1);
      end else begin
        case (state)
          ST_IDLE: begin
            if (bus.start) begin
              dac_code <= MSB_CODE;
              idx      <= IDX_W'(WIDTH - 1);
              state    <= ST_SETTLE;
            end
          end
          ST_SETTLE: begin
            if (timer_done)
              state <= ST_DECIDE;
          end
          ST_DECIDE: begin
            if (!last_bit) begin
              dac_code <= decided_code | (idx_mask >> 1);
              idx      <= idx - 1'b1;
              state    <= ST_SETTLE;
            end else if (restart) begin
              dac_code <= MSB_CODE;
              idx      <= IDX_W'(WIDTH - 1);
              state    <= ST_SETTLE;
            end else begin
              dac_code <= decided_code;
              state    <= ST_DONE;
            end
          end
          ST_DONE: begin
            result       <= done_value;
            result_valid <= 1'b1;
            state        <= ST_IDLE;
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  assign bus.dac_code     = dac_code;
  assign bus.busy         = (state != ST_IDLE);
  assign bus.result       = result;
  assign bus.result_valid = result_valid;
endmodule

// File: tb/tb_sar_adc_controller.sv
// Directed bench for sar_adc_controller with an ideal comparator model (vin >= dac_code).
module tb_sar_adc_controller;
  localparam int W = 8;
  localparam int S = 2;
`ifdef SAR_AVG_EN
  localparam int N_CONV = 4;
`else
  localparam int N_CONV = 1;
`endif
  localparam int CONV_CYC = W * (S + 1);
  localparam int LAT      = N_CONV * CONV_CYC + 1;

  logic         clk = 1'b0;
  logic         reset;
  logic [W-1:0] vin;
  int           checks   = 0;
  int           failures = 0;
  int           pulses;
  logic [W-1:0] trace_seen [W];
  logic [W-1:0] exp_trace  [W];

  sar_adc_controller_if #(.WIDTH(W)) bus ();

  assign bus.comp_in = (vin >= bus.dac_code);

  sar_adc_controller #(
    .WIDTH         (W),
    .SETTLE_CYCLES (S),
    .AVG_LOG2      (2)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Entered at a negedge; returns at the negedge after edge t+LAT+1, or at t+LAT with start raised when chaining.
  task automatic run_conv(input string tag, input logic [W-1:0] v, input logic [W-1:0] exp,
                          input int repulse_k, input bit chain);
    int n_valid;
    n_valid   = 0;
    vin       = v;
    bus.start = 1'b1;
    @(posedge clk);
    for (int k = 0; k <= LAT + 1; k++) begin
      @(negedge clk);
      bus.start = 1'b0;
      if ((k % (S + 1)) == 0 && (k / (S + 1)) < W)
        trace_seen[k / (S + 1)] = bus.dac_code;
      check({tag, "_busy"}, 32'(bus.busy), 32'(k < LAT));
      if (bus.result_valid) n_valid++;
      if (k == LAT) begin
        check({tag, "_valid"}, 32'(bus.result_valid), 32'd1);
        check({tag, "_result"}, 32'(bus.result), 32'(exp));
      end
      if (k == repulse_k) bus.start = 1'b1;
      if (chain && k == LAT) begin
        bus.start = 1'b1;
        break;
      end
    end
    check({tag, "_valid_count"}, 32'(n_valid), 32'd1);
  endtask

  initial begin
    exp_trace = '{8'h80, 8'hC0, 8'hA0, 8'hB0, 8'hA8, 8'hA4, 8'hA6, 8'hA5};
    reset      = 1'b1;
    bus.enable = 1'b1;
    bus.start  = 1'b0;
    vin        = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rst_dac",    32'(bus.dac_code),     32'd0);
    check("rst_busy",   32'(bus.busy),         32'd0);
    check("rst_result", 32'(bus.result),       32'd0);
    check("rst_valid",  32'(bus.result_valid), 32'd0);

    run_conv("a5", 8'hA5, 8'hA5, -1, 1'b0);
    for (int j = 0; j < W; j++)
      check($sformatf("a5_trace%0d", j), 32'(trace_seen[j]), 32'(exp_trace[j]));

    // Abort during bit 4: dropped conversion must not disturb the stored 0xA5.
    vin       = 8'h5A;
    bus.start = 1'b1;
    pulses    = 0;
    @(posedge clk);
    for (int k = 0; k <= LAT + 3; k++) begin
      @(negedge clk);
      bus.start = 1'b0;
      if (bus.result_valid) pulses++;
      if (k == 11) begin
        check("abort_dac",    32'(bus.dac_code), 32'd0);
        check("abort_busy",   32'(bus.busy),     32'd0);
        check("abort_valid",  32'(bus.result_valid), 32'd0);
        check("abort_result", 32'(bus.result),   32'hA5);
      end
      if (k == 10) bus.enable = 1'b0;
    end
    check("abort_valid_count", 32'(pulses), 32'd0);
    check("abort_busy_end",    32'(bus.busy), 32'd0);
    check("abort_result_end",  32'(bus.result), 32'hA5);
    bus.enable = 1'b1;
    @(negedge clk);

    run_conv("repulse", 8'h3C, 8'h3C, 5, 1'b0);

    run_conv("zeros", 8'h00, 8'h00, -1, 1'b1);
    run_conv("ones",  8'hFF, 8'hFF, -1, 1'b0);

    // Reset during the first SETTLE cycle.
    vin       = 8'h77;
    bus.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    reset     = 1'b1;
    @(negedge clk);
    check("midrst_dac",    32'(bus.dac_code),     32'd0);
    check("midrst_busy",   32'(bus.busy),         32'd0);
    check("midrst_result", 32'(bus.result),       32'd0);
    check("midrst_valid",  32'(bus.result_valid), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    run_conv("after_rst", 8'hC3, 8'hC3, -1, 1'b0);

`ifdef SAR_AVG_EN
    vin       = 8'h10;
    bus.start = 1'b1;
    pulses    = 0;
    @(posedge clk);
    for (int k = 0; k <= LAT + 1; k++) begin
      @(negedge clk);
      bus.start = 1'b0;
      if (k == CONV_CYC)     vin = 8'h11;
      if (k == 2 * CONV_CYC) vin = 8'h12;
      if (k == 3 * CONV_CYC) vin = 8'h13;
      if (bus.result_valid) pulses++;
      if (k == LAT) begin
        check("avg_valid",  32'(bus.result_valid), 32'd1);
        check("avg_result", 32'(bus.result),       32'h11);
      end
    end
    check("avg_valid_count", 32'(pulses), 32'd1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
